hwpe_stream_tcdm_reader: RTL and testbench

Read-side counterpart of the TCDM stream sink: fetches `len` 32-bit words from TCDM at `base + i*stride` and emits them in order as an HWPE stream. Single TCDM master port with 1-cycle read latency. A credit-checked response FIFO absorbs stream backpressure, so no response is ever dropped. Sits between the TCDM interconnect and an HWPE datapath input.

---
 rtl/hwpe_stream_package.sv | 22 ++
 rtl/hwpe_stream_tcdm_reader_fifo.sv | 55 +++++
 rtl/hwpe_stream_tcdm_reader.sv | 149 ++++++++++++++
 tb/tb_hwpe_stream_tcdm_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream TCDM source/sink blocks.
package hwpe_stream_package;

  typedef enum logic {
    STREAM_IDLE,
    STREAM_WORKING
  } state_sourcesink_t;

  typedef struct packed {
    logic        req_start;
    logic [31:0] base_addr;
    logic [31:0] stride;
    logic [31:0] len;
  } ctrl_tcdm_reader_t;

  typedef struct packed {
    logic ready_start;
    logic in_progress;
    logic done;
  } flags_tcdm_reader_t;

endpackage

// File: rtl/hwpe_stream_tcdm_reader_fifo.sv
// Synchronous response FIFO; head is read straight from registered storage.
module hwpe_stream_tcdm_reader_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hwpe_stream_tcdm_reader.sv
// Strided TCDM reader: issues len reads and streams the words out in order,
// with request issue throttled by FIFO credit so no response is ever dropped.
module hwpe_stream_tcdm_reader
  import hwpe_stream_package::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_mode_i,
  input  logic                 clear_i,
  input  logic                 ctrl_req_start_i,
  input  logic [31:0]          ctrl_base_addr_i,
  input  logic [31:0]          ctrl_stride_i,
  input  logic [LEN_WIDTH-1:0] ctrl_len_i,
  output logic                 flags_ready_start_o,
  output logic                 flags_in_progress_o,
  output logic                 flags_done_o,
  output logic                 tcdm_req_o,
  input  logic                 tcdm_gnt_i,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_data_o,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  output logic [31:0]          stream_data_o,
  output logic [3:0]           stream_strb_o,
  output logic                 stream_valid_o,
  input  logic                 stream_ready_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  state_sourcesink_t    state_q, state_d;
  flags_tcdm_reader_t   flags;
  logic [31:0]          addr_q, stride_q;
  logic [LEN_WIDTH-1:0] len_q, issue_cnt_q, pop_cnt_q;
  logic                 inflight_q, done_q;
  logic                 start_hs, gnt_hs, push, pop, last_pop, credit_ok, req;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_cnt;
  logic [31:0]          fifo_head;
  logic                 unused_test_mode;

  assign unused_test_mode = test_mode_i;

  assign start_hs = (state_q == STREAM_IDLE) & ctrl_req_start_i & ~clear_i;
  assign pop      = ~fifo_empty & stream_ready_i;
  // Responses are only accepted for reads we actually issued; this also drops
  // a late response arriving just after a clear.
  assign push     = tcdm_r_valid_i & inflight_q;
  assign last_pop = (state_q == STREAM_WORKING) & pop & (pop_cnt_q + LEN_WIDTH'(1) == len_q);

  // Room must exist for what is buffered plus what is still in flight.
  assign credit_ok = (SUM_W'(fifo_cnt) + SUM_W'(inflight_q)) < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop));
  assign req       = (state_q == STREAM_WORKING) & (issue_cnt_q < len_q) & credit_ok;
  assign gnt_hs    = req & tcdm_gnt_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      STREAM_IDLE:    if (start_hs && ctrl_len_i != '0) state_d = STREAM_WORKING;
      STREAM_WORKING: if (last_pop) state_d = STREAM_IDLE;
      default:        state_d = STREAM_IDLE;
    endcase
    if (clear_i) state_d = STREAM_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= STREAM_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else if (clear_i) begin
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      inflight_q <= gnt_hs;
      done_q     <= last_pop | (start_hs & (ctrl_len_i == '0));
      if (start_hs) begin
        addr_q      <= ctrl_base_addr_i;
        stride_q    <= ctrl_stride_i;
        len_q       <= ctrl_len_i;
        issue_cnt_q <= '0;
        pop_cnt_q   <= '0;
      end else begin
        if (gnt_hs) begin
          addr_q      <= addr_q + stride_q;
          issue_cnt_q <= issue_cnt_q + LEN_WIDTH'(1);
        end
        if (pop) pop_cnt_q <= pop_cnt_q + LEN_WIDTH'(1);
      end
    end
  end

  hwpe_stream_tcdm_reader_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (tcdm_r_data_i),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    flags             = '0;
    flags.ready_start = (state_q == STREAM_IDLE);
    flags.in_progress = (state_q == STREAM_WORKING);
    flags.done        = done_q;
  end

  assign flags_ready_start_o = flags.ready_start;
  assign flags_in_progress_o = flags.in_progress;
  assign flags_done_o        = flags.done;

  assign tcdm_req_o  = req;
  assign tcdm_add_o  = req ? addr_q : 32'h0;
  assign tcdm_wen_o  = 1'b1;
  assign tcdm_be_o   = 4'hF;
  assign tcdm_data_o = 32'h0;

  assign stream_valid_o = ~fifo_empty;
  assign stream_data_o  = fifo_empty ? 32'h0 : fifo_head;
  assign stream_strb_o  = fifo_empty ? 4'h0 : 4'hF;

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// Directed + randomized bench for hwpe_stream_tcdm_reader with a TCDM responder model.
module tb_hwpe_stream_tcdm_reader;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LEN_WIDTH  = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_ni, test_mode_i, clear_i, ctrl_req_start_i;
  logic [31:0]          ctrl_base_addr_i, ctrl_stride_i;
  logic [LEN_WIDTH-1:0] ctrl_len_i;
  logic                 flags_ready_start_o, flags_in_progress_o, flags_done_o;
  logic                 tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [31:0]          tcdm_add_o, tcdm_data_o, tcdm_r_data_i, stream_data_o;
  logic [3:0]           tcdm_be_o, stream_strb_o;
  logic                 stream_valid_o, stream_ready_i;

  always #5 clk_i = ~clk_i;

  hwpe_stream_tcdm_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_WIDTH(LEN_WIDTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .clear_i(clear_i),
    .ctrl_req_start_i(ctrl_req_start_i), .ctrl_base_addr_i(ctrl_base_addr_i),
    .ctrl_stride_i(ctrl_stride_i), .ctrl_len_i(ctrl_len_i),
    .flags_ready_start_o(flags_ready_start_o), .flags_in_progress_o(flags_in_progress_o),
    .flags_done_o(flags_done_o), .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o),
    .tcdm_data_o(tcdm_data_o), .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .stream_data_o(stream_data_o), .stream_strb_o(stream_strb_o),
    .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i)
  );

  int unsigned total = 0, pass_cnt = 0, fail_cnt = 0;
  logic [31:0] salt;
  logic        rv_pend;
  logic [31:0] rd_pend;
  logic        s_req, s_valid, s_done, s_rs, s_ip;
  logic [31:0] s_add, s_data;
  logic [3:0]  s_strb;

  // Memory contents seen by the reader: a fixed scramble of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic gnt, input logic rdy, input logic clr);
    tcdm_gnt_i     = gnt;
    stream_ready_i = rdy;
    clear_i        = clr;
    tcdm_r_valid_i = rv_pend;
    tcdm_r_data_i  = rv_pend ? rd_pend : $urandom;
    #2;
    s_req = tcdm_req_o;  s_add = tcdm_add_o;  s_valid = stream_valid_o;
    s_data = stream_data_o; s_strb = stream_strb_o; s_done = flags_done_o;
    s_rs = flags_ready_start_o; s_ip = flags_in_progress_o;
  endtask

  task automatic advance();
    rv_pend = s_req & tcdm_gnt_i;
    rd_pend = mem_word(s_add);
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_transfer(input string nm, input logic [31:0] base, input logic [31:0] stride,
                              input int len, input int gnt_pct, input int rdy_pct,
                              input int hold_cycles, input bit full_rate);
    logic [31:0] exp_add[$];
    logic [31:0] exp_dat[$];
    int n_gnt, n_pop, done_cnt, last_pop_cyc, cyc, hold_left;
    logic g, r, prev_pend;
    logic [31:0] prev_add;
    n_gnt = 0; n_pop = 0; done_cnt = 0; last_pop_cyc = -10; prev_pend = 1'b0; prev_add = '0;
    hold_left = hold_cycles;
    for (int i = 0; i < len; i++) begin
      exp_add.push_back(base + 32'(i) * stride);
      exp_dat.push_back(mem_word(base + 32'(i) * stride));
    end
    ctrl_req_start_i = 1'b1; ctrl_base_addr_i = base; ctrl_stride_i = stride;
    ctrl_len_i = LEN_WIDTH'(len);
    drive(1'b1, 1'b1, 1'b0);
    chk({nm, ":idle_rs"}, 32'(s_rs), 1);
    chk({nm, ":idle_req"}, 32'(s_req), 0);
    advance();
    ctrl_req_start_i = 1'b0; ctrl_base_addr_i = $urandom; ctrl_stride_i = $urandom;
    ctrl_len_i = LEN_WIDTH'($urandom);
    cyc = 1;
    while (cyc < 600 && done_cnt == 0) begin
      g = ($urandom_range(99) < 32'(gnt_pct));
      r = ($urandom_range(99) < 32'(rdy_pct));
      if (n_pop > 0 && hold_left > 0) begin
        r = 1'b0;
        hold_left--;
      end
      drive(g, r, 1'b0);
      if (cyc == 1) begin
        chk({nm, ":ip"}, 32'(s_ip), 1);
        chk({nm, ":rs_busy"}, 32'(s_rs), 0);
      end
      if (hold_cycles > 0 && n_pop > 0 && hold_left == 0 && r == 1'b0)
        chk({nm, ":throttled"}, 32'(s_req), 0);
      if (prev_pend) begin
        chk({nm, ":req_hold"}, 32'(s_req), 1);
        chk({nm, ":add_hold"}, s_add, prev_add);
      end
      chk({nm, ":credit"}, 32'(n_gnt - n_pop <= int'(FIFO_DEPTH)), 1);
      if (s_req && g) begin
        if (n_gnt < len) chk({nm, ":add"}, s_add, exp_add[n_gnt]);
        else chk({nm, ":extra_req"}, 32'(s_req), 0);
        if (full_rate) chk({nm, ":gnt_cyc"}, 32'(cyc), 32'(n_gnt + 1));
        n_gnt++;
      end
      if (s_valid && r) begin
        if (n_pop < len) chk({nm, ":data"}, s_data, exp_dat[n_pop]);
        else chk({nm, ":extra_word"}, 32'(s_valid), 0);
        chk({nm, ":strb"}, 32'(s_strb), 32'hF);
        if (full_rate) chk({nm, ":pop_cyc"}, 32'(cyc), 32'(n_pop + 3));
        n_pop++;
        last_pop_cyc = cyc;
      end
      if (s_done) begin
        done_cnt++;
        chk({nm, ":done_lat"}, 32'(cyc), 32'(last_pop_cyc + 1));
        chk({nm, ":done_rs"}, 32'(s_rs), 1);
        chk({nm, ":words"}, 32'(n_pop), 32'(len));
      end
      prev_pend = s_req & ~g;
      prev_add  = s_add;
      advance();
      cyc++;
    end
    chk({nm, ":done_seen"}, 32'(done_cnt), 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      chk({nm, ":tail_done"}, 32'(s_done), 0);
      chk({nm, ":tail_req"}, 32'(s_req), 0);
      chk({nm, ":tail_valid"}, 32'(s_valid), 0);
      advance();
    end
  endtask

  initial begin
    logic [31:0] cbase, cstride;
    int np;
    salt = $urandom;
    rst_ni = 1'b0; test_mode_i = 1'b0; clear_i = 1'b0; ctrl_req_start_i = 1'b0;
    ctrl_base_addr_i = '0; ctrl_stride_i = '0; ctrl_len_i = '0;
    tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0; stream_ready_i = 1'b0;
    rv_pend = 1'b0; rd_pend = '0;
    #12;
    chk("rst_rs", 32'(flags_ready_start_o), 1);
    chk("rst_ip", 32'(flags_in_progress_o), 0);
    chk("rst_done", 32'(flags_done_o), 0);
    chk("rst_req", 32'(tcdm_req_o), 0);
    chk("rst_add", tcdm_add_o, 0);
    chk("rst_valid", 32'(stream_valid_o), 0);
    chk("rst_strb", 32'(stream_strb_o), 0);
    chk("rst_data", stream_data_o, 0);
    chk("rst_wen", 32'(tcdm_wen_o), 1);
    chk("rst_be", 32'(tcdm_be_o), 32'hF);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    run_transfer("basic", 32'h100, 32'd4, 8, 100, 100, 0, 1'b1);
    run_transfer("backpr", 32'h100, 32'd4, 8, 100, 100, 10, 1'b0);
    run_transfer("gnt50", 32'h100, 32'd4, 8, 50, 100, 0, 1'b0);

    ctrl_req_start_i = 1'b1; ctrl_base_addr_i = 32'h400; ctrl_stride_i = 32'd4; ctrl_len_i = '0;
    drive(1'b1, 1'b1, 1'b0);
    chk("len0_req0", 32'(s_req), 0);
    advance();
    ctrl_req_start_i = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    chk("len0_done", 32'(s_done), 1);
    chk("len0_rs", 32'(s_rs), 1);
    chk("len0_req1", 32'(s_req), 0);
    advance();
    drive(1'b1, 1'b1, 1'b0);
    chk("len0_done_once", 32'(s_done), 0);
    chk("len0_req2", 32'(s_req), 0);
    advance();

    run_transfer("wrap", 32'hFFFF_FFF8, 32'd4, 4, 100, 100, 0, 1'b1);

    cbase = 32'h200; cstride = 32'd8; np = 0;
    ctrl_req_start_i = 1'b1; ctrl_base_addr_i = cbase; ctrl_stride_i = cstride; ctrl_len_i = 16'd8;
    drive(1'b1, 1'b1, 1'b0);
    advance();
    ctrl_req_start_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (s_valid) begin
        chk("clr_data", s_data, mem_word(cbase + 32'(np) * cstride));
        np++;
      end
      advance();
    end
    chk("clr_pops", 32'(np), 3);
    drive(1'b1, 1'b0, 1'b1);
    chk("clr_req_inflight", 32'(s_req), 1);
    advance();
    drive(1'b1, 1'b1, 1'b0);
    chk("clr_late_rvalid", 32'(tcdm_r_valid_i & s_valid), 0);
    chk("clr_rs", 32'(s_rs), 1);
    chk("clr_ip", 32'(s_ip), 0);
    chk("clr_req", 32'(s_req), 0);
    chk("clr_done", 32'(s_done), 0);
    advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      chk("clr_valid_after", 32'(s_valid), 0);
      chk("clr_no_done", 32'(s_done), 0);
      advance();
    end

    run_transfer("post_clr", 32'h300, 32'd12, 6, 100, 100, 0, 1'b1);

    for (int k = 0; k < 4; k++) begin
      run_transfer("rand", $urandom & 32'hFFFF_FFFC, 32'($urandom_range(64)) * 32'd4,
                   int'($urandom_range(1, 20)), int'($urandom_range(40, 100)),
                   int'($urandom_range(30, 100)), 0, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
